fnd_display_scheduler: RTL and testbench

Time-shares the 4-digit FND between the game's display sources: player 1 score, player 2 score, the latest dice roll and the winner banner. Produces the 14-bit `count_reg` value that feeds `fnd_controller`. Sequencing:
- Rotates between the two scores on a fixed dwell.
- A dice result preempts the rotation for a hold period.
- A win event overrides everything until restart.

---
 rtl/fnd_display_scheduler.sv | 147 ++++++++++++++
 tb/tb_fnd_display_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fnd_display_scheduler.sv
// Picks which game value the 4-digit FND shows: rotating player scores,
// a held dice roll, or a sticky winner banner, as a registered 14-bit count.
module fnd_display_scheduler #(
  parameter int unsigned ROTATE_CYCLES = 200_000_000,
  parameter int unsigned HOLD_CYCLES   = 150_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score_p1,
  input  logic [13:0] score_p2,
  input  logic        dice_valid,
  input  logic [2:0]  dice_value,
  input  logic        win_valid,
  input  logic [1:0]  win_player,
  input  logic        restart,
  output logic [13:0] count_reg,
  output logic [2:0]  disp_src
);

  localparam int unsigned DWELL_MAX = (ROTATE_CYCLES > HOLD_CYCLES) ? ROTATE_CYCLES : HOLD_CYCLES;
  localparam int unsigned DW        = (DWELL_MAX > 2) ? $clog2(DWELL_MAX) : 1;
  localparam int unsigned CW        = 14;

  localparam logic [DW-1:0] ROT_LAST  = DW'(ROTATE_CYCLES - 1);
  localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_DICE = 3'd3,
    S_WIN  = 3'd4
  } state_e;

  state_e          state, state_nxt;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic            resume, resume_nxt;       // 0: back to P1, 1: back to P2
  logic [2:0]      dice_latched, dice_nxt;
  logic [1:0]      winner_latched, winner_nxt;
  logic [CW-1:0]   count_nxt;

  logic dice_ok;
  logic win_ok;

  // Out-of-range dice values and winner IDs are dropped as if no pulse arrived
  assign dice_ok = dice_valid && (dice_value != 3'd0) && (dice_value != 3'd7);
  assign win_ok  = win_valid && ((win_player == 2'd1) || (win_player == 2'd2));

  function automatic logic [CW-1:0] sat999(input logic [CW-1:0] s);
    return (s > CW'(999)) ? CW'(999) : s;
  endfunction

  // State and page bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      dwell          <= '0;
      resume         <= 1'b0;
      dice_latched   <= '0;
      winner_latched <= '0;
    end else begin
      state          <= state_nxt;
      dwell          <= dwell_nxt;
      resume         <= resume_nxt;
      dice_latched   <= dice_nxt;
      winner_latched <= winner_nxt;
    end
  end

  // Next state; event priority is restart > win > dice > dwell expiry
  always_comb begin
    state_nxt  = state;
    dwell_nxt  = dwell;
    resume_nxt = resume;
    dice_nxt   = dice_latched;
    winner_nxt = winner_latched;

    case (state)
      S_IDLE: begin
        state_nxt = S_P1;
        dwell_nxt = '0;
      end
      S_WIN: begin
        if (restart) begin
          state_nxt  = S_P1;
          dwell_nxt  = '0;
          winner_nxt = '0;
        end
      end
      default: begin
        if (restart) begin
          state_nxt = S_P1;
          dwell_nxt = '0;
        end else if (win_ok) begin
          state_nxt  = S_WIN;
          dwell_nxt  = '0;
          winner_nxt = win_player;
        end else if (dice_ok) begin
          state_nxt = S_DICE;
          dwell_nxt = '0;
          dice_nxt  = dice_value;
          if (state != S_DICE) resume_nxt = (state == S_P2);
        end else if (state == S_DICE) begin
          if (dwell == HOLD_LAST) begin
            state_nxt = resume ? S_P2 : S_P1;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell + DW'(1);
          end
        end else if (dwell == ROT_LAST) begin
          state_nxt = (state == S_P1) ? S_P2 : S_P1;
          dwell_nxt = '0;
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
    endcase
  end

  // Display value for the page being entered; scores are live, not latched
  always_comb begin
    count_nxt = '0;
    case (state_nxt)
      S_P1:    count_nxt = CW'(1000) + sat999(score_p1);
      S_P2:    count_nxt = CW'(2000) + sat999(score_p2);
      S_DICE:  count_nxt = CW'(dice_nxt);
      S_WIN: begin
        if (winner_nxt == 2'd1)      count_nxt = CW'(1111);
        else if (winner_nxt == 2'd2) count_nxt = CW'(2222);
        else                         count_nxt = '0;
      end
      default: count_nxt = '0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      disp_src  <= 3'd0;
    end else begin
      count_reg <= count_nxt;
      disp_src  <= 3'(state_nxt);
    end
  end

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed bench for fnd_display_scheduler with short dwell/hold so every
// page boundary can be walked edge by edge.
module tb_fnd_display_scheduler;

  logic        clk;
  logic        rst;
  logic [13:0] score_p1;
  logic [13:0] score_p2;
  logic        dice_valid;
  logic [2:0]  dice_value;
  logic        win_valid;
  logic [1:0]  win_player;
  logic        restart;
  logic [13:0] count_reg;
  logic [2:0]  disp_src;

  int n_tests;
  int n_fail;

  fnd_display_scheduler #(
    .ROTATE_CYCLES(8),
    .HOLD_CYCLES  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .dice_valid(dice_valid),
    .dice_value(dice_value),
    .win_valid (win_valid),
    .win_player(win_player),
    .restart   (restart),
    .count_reg (count_reg),
    .disp_src  (disp_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_page(input string tag, input int cnt, input int src);
    check({tag, ".count"}, 32'(count_reg), 32'(cnt));
    check({tag, ".src"},   32'(disp_src),  32'(src));
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    score_p1   = 14'd42;
    score_p2   = 14'd1234;
    dice_valid = 1'b0;
    dice_value = 3'd0;
    win_valid  = 1'b0;
    win_player = 2'd0;
    restart    = 1'b0;

    #1;
    check_page("reset", 0, 0);
    tick(2);
    check_page("reset_held", 0, 0);
    rst = 1'b1;

    // 1. rotation
    tick(1);  check_page("rot_p1_first", 1042, 1);
    tick(7);  check_page("rot_p1_last", 1042, 1);
    tick(1);  check_page("rot_p2_first", 2999, 2);
    tick(7);  check_page("rot_p2_last", 2999, 2);
    tick(1);  check_page("rot_p1_again", 1042, 1);

    // 2. dice preempts P2 in its third cycle
    tick(8);  check_page("p2_enter", 2999, 2);
    tick(2);  check_page("p2_cycle3", 2999, 2);
    dice_valid = 1'b1; dice_value = 3'd5;
    tick(1);  check_page("dice5_first", 5, 3);
    dice_valid = 1'b0;
    tick(4);  check_page("dice5_last", 5, 3);
    tick(1);  check_page("resume_p2", 2999, 2);
    tick(7);  check_page("resume_p2_last", 2999, 2);
    tick(1);  check_page("resume_p1", 1042, 1);

    // live score, saturation boundary
    score_p1 = 14'd1500;
    tick(1);  check_page("sat_1500", 1999, 1);
    score_p1 = 14'd999;
    tick(1);  check_page("sat_999", 1999, 1);
    score_p1 = 14'd42;

    // 3. retriggered dice, illegal dice value ignored
    restart = 1'b1;
    tick(1);  check_page("restart_p1", 1042, 1);
    restart = 1'b0;
    dice_valid = 1'b1; dice_value = 3'd3;
    tick(1);  check_page("dice3_first", 3, 3);
    dice_valid = 1'b0;
    tick(2);  check_page("dice3_cycle3", 3, 3);
    dice_valid = 1'b1; dice_value = 3'd6;
    tick(1);  check_page("dice6_first", 6, 3);
    dice_value = 3'd0;
    tick(1);  check_page("dice0_ignored", 6, 3);
    dice_valid = 1'b0;
    tick(3);  check_page("dice6_last", 6, 3);
    tick(1);  check_page("dice_resume_p1", 1042, 1);

    // 4. win and dice in the same cycle, win sticky
    win_valid = 1'b1; win_player = 2'd2;
    dice_valid = 1'b1; dice_value = 3'd4;
    tick(1);  check_page("win2", 2222, 4);
    win_valid = 1'b0; dice_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dice_valid = (i % 4 == 0);
      dice_value = 3'd2;
      win_valid  = (i == 10);
      win_player = 2'd1;
      tick(1);
      check("win_sticky", 32'(count_reg), 32'd2222);
    end
    dice_valid = 1'b0; win_valid = 1'b0;
    check_page("win_after20", 2222, 4);
    restart = 1'b1;
    tick(1);  check_page("win_restart", 1042, 1);
    restart = 1'b0;

    // 5. restart beats win; illegal winners ignored
    tick(8);  check_page("p2_before_restart", 2999, 2);
    restart = 1'b1; win_valid = 1'b1; win_player = 2'd1;
    tick(1);  check_page("restart_over_win", 1042, 1);
    restart = 1'b0; win_player = 2'd3;
    tick(1);  check_page("win3_ignored", 1042, 1);
    win_player = 2'd0;
    tick(1);  check_page("win0_ignored", 1042, 1);
    win_valid = 1'b0;
    dice_valid = 1'b1; dice_value = 3'd7;
    tick(1);  check_page("dice7_ignored", 1042, 1);
    dice_valid = 1'b0;

    // 6. asynchronous reset mid-hold
    dice_valid = 1'b1; dice_value = 3'd1;
    tick(1);  check_page("dice1", 1, 3);
    dice_valid = 1'b0;
    tick(1);
    #2;
    rst = 1'b0;
    #1;
    check_page("async_reset", 0, 0);
    tick(2);  check_page("async_reset_held", 0, 0);
    rst = 1'b1;
    tick(1);  check_page("rerelease_p1", 1042, 1);
    tick(7);  check_page("rerelease_p1_last", 1042, 1);
    tick(1);  check_page("rerelease_p2", 2999, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
